// File: rtl/aes_key_expansion.sv
// AES-128 round-key provider: expands a loaded key one word per clock (40 clocks) and serves round keys one clock after a request.
// No backpressure: requests wait until serviceable; define AES_KEY_EXP_EARLY_SERVE_EN to serve finished keys during expansion.
module aes_key_expansion #(
  parameter int NO_ROWS   = 4,
  parameter int NO_COLS   = 4,
  parameter int NO_ROUNDS = 10
) (
  input  logic                                 aes_clk,
  input  logic                                 resetn,
  input  logic                                 key_exp_en,
  input  logic                                 key_load_i,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] cipher_key_i,
  input  logic                                 key_req_i,
  input  logic [3:0]                           key_sel_i,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] round_key_o,
  output logic                                 key_vld_o,
  output logic                                 key_sel_err_o,
  output logic                                 key_exp_busy_o,
  output logic                                 key_exp_done_o
);

  localparam int NO_WORDS = NO_COLS * (NO_ROUNDS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]                           state_q, state_d;
  logic [5:0]                           cnt_q, cnt_d;
  logic [31:0]                          w_q [NO_WORDS];
  logic [31:0]                          w_d [NO_WORDS];
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] rk_q, rk_d;
  logic                                 vld_q, vld_d, err_q, err_d;
  logic [31:0]                          prev_w, temp_w;
  logic [5:0]                           sel_base;
  logic                                 can_serve;

  assign sel_base = {key_sel_i, 2'b00};

  // Round-key boundary words get RotWord/SubWord/Rcon; others pass w[i-1] through.
  always_comb begin
    prev_w = w_q[cnt_q - 6'd1];
    temp_w = prev_w;
    if (cnt_q[1:0] == 2'b00) begin
      temp_w = {sbox(prev_w[23:16]) ^ rcon(cnt_q[5:2]), sbox(prev_w[15:8]),
                sbox(prev_w[7:0]), sbox(prev_w[31:24])};
    end
  end

`ifdef AES_KEY_EXP_EARLY_SERVE_EN
  assign can_serve = (state_q == READY) ||
                     ((state_q == EXPAND) && (cnt_q > sel_base + 6'd3));
`else
  assign can_serve = (state_q == READY);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    rk_d    = rk_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (!key_exp_en) begin
      state_d = IDLE;
    end else if (key_load_i) begin
      for (int c = 0; c < NO_COLS; c++)
        for (int r = 0; r < NO_ROWS; r++)
          w_d[c][31-8*r -: 8] = cipher_key_i[r][c];
      cnt_d   = 6'd4;
      state_d = EXPAND;
    end else begin
      if (state_q == EXPAND) begin
        w_d[cnt_q] = w_q[cnt_q - 6'd4] ^ temp_w;
        cnt_d      = cnt_q + 6'd1;
        if (cnt_q == 6'(NO_WORDS - 1)) state_d = READY;
      end
      // Unserviceable requests simply leave vld low; the requester keeps req up.
      if (key_req_i) begin
        if (key_sel_i > 4'(NO_ROUNDS)) begin
          err_d = 1'b1;
        end else if (can_serve) begin
          for (int c = 0; c < NO_COLS; c++)
            for (int r = 0; r < NO_ROWS; r++)
              rk_d[r][c] = w_q[sel_base + 6'(c)][31-8*r -: 8];
          vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rk_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NO_WORDS; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      w_q     <= w_d;
    end
  end

  assign round_key_o    = rk_q;
  assign key_vld_o      = vld_q;
  assign key_sel_err_o  = err_q;
  assign key_exp_busy_o = (state_q == EXPAND);
  assign key_exp_done_o = (state_q == READY);

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion using the FIPS-197 A.1 key schedule.
module tb_aes_key_expansion;

  typedef logic [3:0][3:0][7:0] mat_t;
  typedef struct {
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;

  logic       aes_clk = 1'b0;
  logic       resetn = 1'b1;
  logic       key_exp_en = 1'b0;
  logic       key_load_i = 1'b0;
  logic       key_req_i = 1'b0;
  logic [3:0] key_sel_i = 4'd0;
  mat_t       cipher_key_i;
  mat_t       round_key_o;
  logic       key_vld_o, key_sel_err_o, key_exp_busy_o, key_exp_done_o;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv [11];
  int first_vld;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expansion dut (
    .aes_clk       (aes_clk),
    .resetn        (resetn),
    .key_exp_en    (key_exp_en),
    .key_load_i    (key_load_i),
    .cipher_key_i  (cipher_key_i),
    .key_req_i     (key_req_i),
    .key_sel_i     (key_sel_i),
    .round_key_o   (round_key_o),
    .key_vld_o     (key_vld_o),
    .key_sel_err_o (key_sel_err_o),
    .key_exp_busy_o(key_exp_busy_o),
    .key_exp_done_o(key_exp_done_o)
  );

  always #5 aes_clk = ~aes_clk;

  // FIPS byte k lives at matrix [k%4][k/4].
  function automatic mat_t to_mat(input logic [127:0] h);
    mat_t m;
    for (int k = 0; k < 16; k++) m[k%4][k/4] = h[127-8*k -: 8];
    return m;
  endfunction

  function automatic logic [127:0] from_mat(input mat_t m);
    logic [127:0] h;
    for (int k = 0; k < 16; k++) h[127-8*k -: 8] = m[k%4][k/4];
    return h;
  endfunction

  // {busy, done, vld, err}
  function automatic logic [3:0] status();
    return {key_exp_busy_o, key_exp_done_o, key_vld_o, key_sel_err_o};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aes_clk);
    #1;
  endtask

  task automatic load_key();
    key_load_i = 1'b1;
    tick();
    key_load_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tv[0]  = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tv[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tv[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tv[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tv[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tv[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tv[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tv[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tv[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tv[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tv[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
`ifdef AES_KEY_EXP_EARLY_SERVE_EN
    first_vld = 5;
`else
    first_vld = 41;
`endif
    cipher_key_i = to_mat(KEY);

    #2 resetn = 1'b0;
    #2;
    chk("reset_status", 128'(status()), 128'h0);
    chk("reset_round_key", from_mat(round_key_o), 128'h0);
    tick();
    resetn = 1'b1;
    key_exp_en = 1'b1;

    // Request pending from IDLE, held through the whole expansion.
    key_req_i = 1'b1;
    key_sel_i = 4'd1;
    tick();
    chk("idle_req_vld", 128'(key_vld_o), 128'h0);
    load_key();
    chk("edge0_status", 128'(status()), 128'b1000);
    for (int k = 1; k <= 41; k++) begin
      tick();
      chk($sformatf("expand_edge%0d", k), 128'(status()),
          128'({k <= 39, k >= 40, k >= first_vld, 1'b0}));
    end
    chk("sel1_key", from_mat(round_key_o), tv[9].exp);
    key_req_i = 1'b0;
    tick();
    chk("drop_vld", 128'(key_vld_o), 128'h0);
    chk("drop_hold", from_mat(round_key_o), tv[9].exp);

    // Decryption order 10..0 with a one-cycle gap between requests.
    for (int i = 0; i < 11; i++) begin
      key_req_i = 1'b1;
      key_sel_i = tv[i].sel;
      tick();
      chk($sformatf("dec_vld_sel%0d", tv[i].sel), 128'(key_vld_o), 128'h1);
      chk($sformatf("dec_key_sel%0d", tv[i].sel), from_mat(round_key_o), tv[i].exp);
      key_req_i = 1'b0;
      tick();
      chk($sformatf("dec_gap_sel%0d", tv[i].sel), 128'(key_vld_o), 128'h0);
    end

    // Illegal selector.
    key_req_i = 1'b1;
    key_sel_i = 4'd11;
    tick();
    chk("err_status", 128'(status()), 128'b0101);
    chk("err_key_hold", from_mat(round_key_o), KEY);
    key_req_i = 1'b0;
    tick();
    chk("err_pulse_end", 128'(status()), 128'b0100);

    // Load and request together in READY: the load wins.
    key_req_i = 1'b1;
    key_sel_i = 4'd2;
    load_key();
    key_req_i = 1'b0;
    chk("load_wins", 128'(status()), 128'b1000);
    ticks(19);
    load_key();
    chk("restart_edge20", 128'(status()), 128'b1000);
    ticks(39);
    chk("restart_not_done", 128'(status()), 128'b1000);
    tick();
    chk("restart_done", 128'(status()), 128'b0100);

    // Disable while serving.
    key_req_i = 1'b1;
    key_sel_i = 4'd5;
    tick();
    chk("pre_disable_key", from_mat(round_key_o), tv[5].exp);
    key_exp_en = 1'b0;
    tick();
    chk("disable_status", 128'(status()), 128'b0000);
    key_req_i = 1'b0;
    key_load_i = 1'b1;
    tick();
    key_load_i = 1'b0;
    chk("disabled_load_ignored", 128'(status()), 128'b0000);
    key_exp_en = 1'b1;

    // Async reset mid-expansion, then a clean reload.
    load_key();
    ticks(15);
    #2 resetn = 1'b0;
    #1;
    chk("areset_status", 128'(status()), 128'h0);
    chk("areset_key", from_mat(round_key_o), 128'h0);
    tick();
    resetn = 1'b1;
    load_key();
    ticks(40);
    chk("reload_done", 128'(status()), 128'b0100);
    key_req_i = 1'b1;
    key_sel_i = 4'd10;
    tick();
    chk("reload_sel10", from_mat(round_key_o), tv[0].exp);
    key_sel_i = 4'd3;
    tick();
    chk("reload_sel3", from_mat(round_key_o), tv[7].exp);
    key_req_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Round-key provider for the AES-128 cores. It answers their `key_req`/`key_sel`/`key_vld` handshake.
- On a load command it captures a 4x4 cipher-key matrix and expands it to round keys 0..10 (44 words), one word per clock, into an internal buffer.
- It then serves any round key on request, in any order, including the descending 10..0 order used by the decryption core.

Parameters:
- NO_ROWS, 4, rows of the key matrix (fixed at 4 for AES-128)
- NO_COLS, 4, columns of the key matrix (fixed at 4 for AES-128)
- NO_ROUNDS, 10, number of round keys after key 0

Ports:
- aes_clk  input  1  clock, rising-edge
- resetn  input  1  asynchronous reset, active-low
- key_exp_en  input  1  block enable
- key_load_i  input  1  one-cycle load command
- cipher_key_i  input  8 x [NO_ROWS][NO_COLS]  cipher key; byte k of the FIPS key maps to [k%4][k/4]
- key_req_i  input  1  round-key request from a core
- key_sel_i  input  4  requested round index, 0..10
- round_key_o  output  8 x [NO_ROWS][NO_COLS]  served round key, same byte mapping
- key_vld_o  output  1  round_key_o is valid for key_sel_i
- key_sel_err_o  output  1  one-cycle pulse: key_sel_i > 10 while requested
- key_exp_busy_o  output  1  expansion in progress
- key_exp_done_o  output  1  all 11 round keys available

Behaviour:
- Reset (async, resetn=0):
  - round_key_o = 0, key_vld_o = 0, key_sel_err_o = 0, key_exp_busy_o = 0, key_exp_done_o = 0.
  - Word buffer cleared, word counter cleared, FSM to IDLE.
  - Reset mid-expansion or mid-serve aborts immediately.
- Word format: w[c] = {m[0][c], m[1][c], m[2][c], m[3][c]}. Round key r = w[4r..4r+3], with w[4r+c] placed in column c.
- FSM states are IDLE, EXPAND, READY.
  - IDLE: all status low. key_load_i=1 & key_exp_en=1 → write w[0..3] from cipher_key_i, set counter = 4, go to EXPAND.
  - EXPAND: each edge writes w[i], i = counter, then counter += 1.
    - w[i] = w[i-4] ^ temp.
    - temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/4], 24'h0} when i%4 == 0; otherwise temp = w[i-1].
    - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
    - SubWord applies the forward AES S-box bytewise, implemented inside this block.
    - After writing w[43], go to READY.
    - key_exp_busy_o = 1 throughout EXPAND.
  - READY: key_exp_done_o = 1.
    - key_load_i=1 → recapture the key and go to EXPAND. done drops and vld drops on that edge.
- Latency: key_load_i sampled at edge 0 → w[4..43] written at edges 1..40 → key_exp_done_o high after edge 40.
- Serve (READY, or per the optional feature):
  - Each edge with key_req_i=1 and key_sel_i <= 10: round_key_o <= round key[key_sel_i], key_vld_o <= 1.
  - A request therefore takes one cycle of latency.
  - While key_req_i stays high with a stable sel, key_vld_o stays high and data stays constant.
  - key_req_i=0 → key_vld_o <= 0. round_key_o holds its last value, because cores sample it after dropping the request.
  - key_sel_i changed while key_req_i is held: the new key and key_vld_o=1 appear on the next edge. The requester must not trust key_vld_o in the cycle its sel changes.
  - key_sel_i > 10 with req: key_vld_o <= 0, key_sel_err_o pulses for one cycle, round_key_o is unchanged.
- A request while not serviceable (IDLE, or EXPAND without the feature) gives key_vld_o = 0. The request is not dropped: it is served on the first serviceable edge, provided req is still high.
- key_load_i during EXPAND: restart. Recapture the key, counter = 4, vld = 0.
- key_exp_en = 0: on the next edge go to IDLE and clear busy, done and vld. Buffer contents are invalid and a fresh load is required. key_load_i is ignored while disabled.
- Simultaneous key_load_i and key_req_i in READY: the load wins and vld = 0.

Optional Feature:
- Macro: AES_KEY_EXP_EARLY_SERVE_EN.
- Defined: during EXPAND, a request for sel is served once w[4*sel+3] has been written (counter > 4*sel+3). Example: sel 0 is serviceable in the first EXPAND cycle; sel 10 only in READY. Until then the request is held pending as above.
- Undefined: requests are served only in READY.

Test Plan:
- Expansion vector: reset, key 2b7e151628aed2a6abf7158809cf4f3c, load at edge 0 → key_exp_done_o rises after edge 40 and busy is high for edges 1..40. Requests with sel=1 give a0fafe1788542cb123a339392a6c7605. sel=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- Decryption order: hold req and step sel 10, 9, … 0, dropping req for one cycle between steps → each vld appears one cycle after req. Data matches FIPS-197 A.1, and sel=0 returns the cipher key.
- Error/hold: request sel=11 → key_sel_err_o pulses once, vld = 0, round_key_o unchanged. Request before load → vld stays 0 until READY, then is served.
- Restart/disable: key_load_i at edge 20 of EXPAND → done after a further 40 edges. Separately, key_exp_en=0 in READY → done = 0 and vld = 0 next edge.
- Async reset mid-EXPAND (edge 15) → all outputs 0 immediately. A subsequent load completes normally.
- With AES_KEY_EXP_EARLY_SERVE_EN defined: req sel=1 held from load → vld asserts on the edge after w[7] is written (edge 5). Without the macro, vld asserts at edge 41.
